mw_dmem_seq: RTL

- Memory-access sequencer for the MW stage of the 3-stage RV32I pipeline.
- Consumes MWControl outputs (w_mask, re) plus the ALU address and store data, and drives a valid/ready request to the data cache.
- Waits for the load response, then aligns and sign- or zero-extends the loaded data.
- Stalls the pipeline until the access completes.

---
 rtl/mw_dmem_seq_pkg.sv | 62 ++++++
 rtl/mw_load_align.sv | 35 +++
 rtl/mw_dmem_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mw_dmem_seq_pkg.sv
// Shared constants for the MW-stage data-memory sequencer: FSM state encoding,
// RV32I load/store funct3 encodings, store size masks, and small helpers that
// derive the effective byte offset and (optionally) misalignment of an access.
package mw_dmem_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Load types (funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store types (funct3)
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Unshifted store size masks
  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  // Byte lane a store starts on. Address bits finer than the access size are
  // dropped: halves use addr[1] only, words always start at lane 0.
  function automatic logic [1:0] store_offset(input logic [3:0] w_mask,
                                              input logic [1:0] addr_lo);
    case (w_mask)
      MASK_HALF: return {addr_lo[1], 1'b0};
      MASK_WORD: return 2'b00;
      default:   return addr_lo;
    endcase
  endfunction

  // Misalignment: loads are sized by funct3, stores by their mask.
  function automatic logic is_misaligned(input logic       re,
                                         input logic [2:0] funct3,
                                         input logic [3:0] w_mask,
                                         input logic [1:0] addr_lo);
    if (re) begin
      case (funct3[1:0])
        2'b01:   return addr_lo[0];
        2'b10:   return addr_lo != 2'b00;
        default: return 1'b0;
      endcase
    end else begin
      case (w_mask)
        MASK_HALF: return addr_lo[0];
        MASK_WORD: return addr_lo != 2'b00;
        default:   return 1'b0;
      endcase
    end
  endfunction

endpackage

// File: rtl/mw_load_align.sv
// Load data aligner: picks the byte/half/word out of a raw dcache word and
// sign- or zero-extends it. Purely combinational (0 cycles), no flow control.
// Ports: resp_data (raw word), addr (byte offset), funct3 (load type) -> load_data_next.
module mw_load_align
  import mw_dmem_seq_pkg::*;
(
  input  logic [31:0] resp_data,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data_next
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = resp_data[7:0];
      2'd1:    byte_sel = resp_data[15:8];
      2'd2:    byte_sel = resp_data[23:16];
      default: byte_sel = resp_data[31:24];
    endcase
    // Halves are selected by addr[1] alone; addr[0] is ignored.
    half_sel = addr[1] ? resp_data[31:16] : resp_data[15:0];

    case (funct3)
      F3_LB:   load_data_next = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data_next = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  load_data_next = {24'd0, byte_sel};
      F3_LHU:  load_data_next = {16'd0, half_sel};
      default: load_data_next = resp_data;  // LW and undefined types: raw word
    endcase
  end

endmodule

// File: rtl/mw_dmem_seq.sv
// MW-stage memory sequencer: issues one valid/ready dcache request per load or
// store and returns the aligned, extended load result.
// Latency: store 3 cycles accept..done, load 4 cycles; stall held until done.
// Backpressure: request held stable while req_ready is low; waits indefinitely on resp_valid.
// Ports: pipeline side (in_valid, addr, wdata, w_mask, re, funct3, stall, done,
// load_data), dcache side (req_* out, req_ready, resp_valid, resp_data in).
// Optional: define MW_MISALIGN_TRAP_EN to trap misaligned accesses (adds the
// misaligned output; no request is issued for a trapped access).
module mw_dmem_seq
  import mw_dmem_seq_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [3:0]        w_mask,
  input  logic              re,
  input  logic [2:0]        funct3,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [AWIDTH-1:0] req_addr,
  output logic [DWIDTH-1:0] req_wdata,
  output logic [3:0]        req_we,
  output logic              req_re,
  input  logic              resp_valid,
  input  logic [DWIDTH-1:0] resp_data,
  output logic [DWIDTH-1:0] load_data,
  output logic              done,
  output logic              stall
`ifdef MW_MISALIGN_TRAP_EN
  ,
  output logic              misaligned
`endif
);

  state_t      state, state_nxt;
  logic        mem_op;
  logic        accept;
  logic        trap;
  logic [1:0]  st_off;
  logic [1:0]  off_q;     // original byte offset, needed by the load aligner
  logic [2:0]  f3_q;
  logic [31:0] load_data_next;

  assign mem_op = re | (|w_mask);
  assign accept = (state == S_IDLE) && in_valid && mem_op;
  assign st_off = store_offset(w_mask, addr[1:0]);

`ifdef MW_MISALIGN_TRAP_EN
  logic mis_q;
  assign trap       = is_misaligned(re, funct3, w_mask, addr[1:0]);
  assign misaligned = done & mis_q;
`else
  assign trap = 1'b0;
`endif

  mw_load_align u_align (
    .resp_data      (resp_data),
    .addr           (off_q),
    .funct3         (f3_q),
    .load_data_next (load_data_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      req_addr  <= '0;
      req_wdata <= '0;
      req_we    <= MASK_NONE;
      req_re    <= 1'b0;
      load_data <= '0;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
`ifdef MW_MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_addr  <= {addr[AWIDTH-1:2], 2'b00};
        req_wdata <= wdata << {st_off, 3'b000};
        // A load never writes, whatever mask came along with it.
        req_we    <= re ? MASK_NONE : (w_mask << st_off);
        req_re    <= re;
        off_q     <= addr[1:0];
        f3_q      <= funct3;
`ifdef MW_MISALIGN_TRAP_EN
        mis_q     <= trap;
`endif
      end
      if ((state == S_RESP) && resp_valid) begin
        load_data <= load_data_next;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    done      = 1'b0;
    stall     = 1'b0;
    case (state)
      S_IDLE: begin
        stall = in_valid & mem_op;
        if (accept) begin
          state_nxt = trap ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        req_valid = 1'b1;
        stall     = 1'b1;
        if (req_ready) begin
          state_nxt = req_re ? S_RESP : S_DONE;
        end
      end
      S_RESP: begin
        stall = 1'b1;
        if (resp_valid) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // Pipeline is released this cycle; in_valid still shows the same
        // instruction, so it is not looked at until we are back in IDLE.
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
